// File: rtl/riscv_pkg.sv
// Shared definitions for the 8-bit RISC-V pipeline: bubble word, fetch FSM
// states and the sequential PC step.
package riscv_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

  // Sequential fetch advances one 32-bit word.
  localparam int PC_INC = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_hold_buffer.sv
// One-entry skid register that parks a fetched {pc, instr} pair while the
// pipeline is stalled. Clear wins over load so a flush always empties it.
module if_hold_buffer #(
  parameter int PC_SIZE = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [PC_SIZE-1:0] load_pc,
  input  logic [31:0]        load_instr,
  output logic               valid,
  output logic [PC_SIZE-1:0] hold_pc,
  output logic [31:0]        hold_instr
);

  // Occupancy flag: only control state is reset.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload: captured on load, meaningless while valid is low.
  always_ff @(posedge clock) begin
    if (load && !clear) begin
      hold_pc    <= load_pc;
      hold_instr <= load_instr;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ack fetch handshake and
// drives the IF/ID register. A redirect that lands while a request is still
// in flight sets kill so the stale response is dropped when it arrives; the
// outstanding address is kept in imem_addr, separate from pc, so the
// handshake stays stable while pc already points at the branch target.
module if_stage
  import riscv_pkg::*;
#(
  parameter int                 PC_SIZE   = 10,
  parameter logic [PC_SIZE-1:0] RESET_PC  = '0,
  parameter logic [31:0]        NOP_INSTR = RV_NOP_INSTR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_SIZE-1:0] branch_target,
  output logic               imem_req,
  output logic [PC_SIZE-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ack,
  output logic [PC_SIZE-1:0] PC_out,
  output logic [31:0]        instruction,
  output logic               if_valid
);

  localparam logic [PC_SIZE-1:0] PC_STEP = PC_SIZE'(PC_INC);

  fetch_state_t       state;
  logic [PC_SIZE-1:0] pc;
  logic               kill;
  logic [PC_SIZE-1:0] tgt_aligned;
  logic [PC_SIZE-1:0] pc_plus;
  logic               hb_load;
  logic               hb_clear;
  logic               hb_valid;
  logic [PC_SIZE-1:0] hb_pc;
  logic [31:0]        hb_instr;
  logic               unused_tgt_bits;

  assign tgt_aligned     = {branch_target[PC_SIZE-1:2], 2'b00};
  assign unused_tgt_bits = ^branch_target[1:0];
  // Wraps modulo 2^PC_SIZE by width truncation.
  assign pc_plus         = pc + PC_STEP;

  assign hb_load  = (state == S_REQ) && imem_ack && !kill && stall && !branch_taken;
  assign hb_clear = branch_taken || ((state == S_HOLD) && !stall);

  if_hold_buffer #(
    .PC_SIZE (PC_SIZE)
  ) u_hold (
    .clock      (clock),
    .reset      (reset),
    .load       (hb_load),
    .clear      (hb_clear),
    .load_pc    (pc),
    .load_instr (imem_rdata),
    .valid      (hb_valid),
    .hold_pc    (hb_pc),
    .hold_instr (hb_instr)
  );

  // Fetch FSM, PC and IF/ID register; reset and flush take priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      PC_out      <= '0;
      instruction <= NOP_INSTR;
      if_valid    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
          if (branch_taken) begin
            pc          <= tgt_aligned;
            imem_addr   <= tgt_aligned;
            instruction <= NOP_INSTR;
            if_valid    <= 1'b0;
          end else begin
            imem_addr <= pc;
          end
        end

        S_REQ: begin
          if (branch_taken) begin
            instruction <= NOP_INSTR;
            if_valid    <= 1'b0;
            pc          <= tgt_aligned;
            // Same-cycle ack retires the old request; otherwise it is
            // still in flight and its response must be thrown away.
            kill        <= !imem_ack;
            if (imem_ack) begin
              imem_addr <= tgt_aligned;
            end
          end else if (imem_ack && kill) begin
            kill      <= 1'b0;
            imem_addr <= pc;
          end else if (imem_ack && !stall) begin
            PC_out      <= pc;
            instruction <= imem_rdata;
            if_valid    <= 1'b1;
            pc          <= pc_plus;
            imem_addr   <= pc_plus;
          end else if (imem_ack) begin
            pc        <= pc_plus;
            imem_addr <= pc_plus;
            imem_req  <= 1'b0;
            state     <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (branch_taken) begin
            instruction <= NOP_INSTR;
            if_valid    <= 1'b0;
            pc          <= tgt_aligned;
            imem_addr   <= tgt_aligned;
            imem_req    <= 1'b1;
            state       <= S_REQ;
          end else if (!stall) begin
            PC_out      <= hb_pc;
            instruction <= hb_instr;
            if_valid    <= hb_valid;
            imem_req    <= 1'b1;
            state       <= S_REQ;
          end
        end

        default: begin
          state    <= S_IDLE;
          kill     <= 1'b0;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 8-bit RISC-V pipeline.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Drives the IF/ID pipeline register that feeds the decode stage: PC_out, instruction, if_valid.
- Handles stall from the hazard unit, and branch redirect/flush from the branch-resolution logic.

Parameters:
- PC_SIZE, 10: width of the PC and of the instruction-memory byte address.
- RESET_PC, 0: PC value loaded on reset.
- NOP_INSTR, 32'h00000013: bubble instruction (addi x0,x0,0) inserted on flush and reset.

Ports:
- clock  input  1  system clock; all state on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold the IF/ID register and the PC.
- branch_taken  input  1  one-cycle pulse: redirect fetch to branch_target and flush IF/ID.
- branch_target  input  PC_SIZE  redirect address; word aligned, bits [1:0] ignored.
- imem_req  output  1  fetch request; held high until imem_ack.
- imem_addr  output  PC_SIZE  fetch byte address; stable while imem_req=1 and imem_ack=0.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- imem_ack  input  1  memory response; may arrive in the request cycle or any later cycle.
- PC_out  output  PC_SIZE  PC of the instruction in IF/ID; goes to decode PC_out_in.
- instruction  output  32  IF/ID instruction word.
- if_valid  output  1  1 = instruction is a real fetched word; 0 = bubble (NOP_INSTR).

Behaviour:
- Reset (synchronous, any state, including mid-request):
  - pc=RESET_PC, PC_out=0, instruction=NOP_INSTR, if_valid=0.
  - imem_req=0, kill=0, hold buffer empty, FSM=S_IDLE.
  - An ack arriving in the reset cycle is ignored.
- FSM states:
  - S_IDLE: one cycle after reset; imem_req=0. Next state is S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc.
  - S_HOLD: a response has been captured while stall=1; imem_req=0.
- S_REQ transitions:
  - On imem_ack with kill=1: discard imem_rdata, clear kill, pc unchanged (already the target), stay in S_REQ.
  - On imem_ack with stall=0: IF/ID <= {pc, imem_rdata, valid=1}; pc <= pc+4; stay in S_REQ. Sustains 1 instr/cycle with a zero-wait memory.
  - On imem_ack with stall=1: capture {pc, imem_rdata} in the hold buffer; pc <= pc+4; go to S_HOLD.
- S_HOLD transitions:
  - When stall drops: IF/ID <= hold buffer, valid=1; go to S_REQ.
- stall=1 with no branch: IF/ID and pc hold their values. An outstanding request stays outstanding (the address must not change).
- branch_taken=1 (overrides stall, highest priority after reset):
  - IF/ID <= {PC_out unchanged, NOP_INSTR, valid=0}; pc <= {branch_target[PC_SIZE-1:2], 2'b00}.
  - The hold buffer is discarded; S_HOLD goes to S_REQ.
  - If S_REQ is outstanding with no ack this cycle: set kill=1.
  - If the ack arrives in the same cycle as branch_taken: the data is discarded and no kill is needed.
  - A new request to the target starts the next cycle.
- PC arithmetic: pc+4 is modulo 2^PC_SIZE. 0x3FC wraps to 0x000 with no flag.
- Latency: with a zero-wait memory, the first valid instruction appears in IF/ID 2 cycles after reset deasserts. Redirect to the first target instruction in IF/ID takes 2 cycles.
- Handshake rule: imem_req never drops and imem_addr never changes between request assertion and ack, except on reset.
- Every output is registered; none depends combinationally on any input.

Decomposition:
- Shared package (riscv_pkg):
  - NOP_INSTR constant.
  - FSM state enum {S_IDLE, S_REQ, S_HOLD}.
  - PC increment constant 4.
- One natural sub-module: if_hold_buffer, a one-entry skid register holding {pc, instr} with load/clear/valid.
- PC and FSM stay in the top module.

Test Plan:
1. Reset, then zero-wait memory returning addr-indexed words. Required: imem_addr 0x000, 0x004, 0x008 on consecutive cycles; if_valid=1 from cycle 2; PC_out follows 0x000, 0x004, 0x008 with matching instructions.
2. Two-wait-state memory (ack 2 cycles after req). Required: imem_addr holds 0x004 for 3 cycles; IF/ID updates once per 3 cycles; no duplicated or skipped PC.
3. stall=1 for 3 cycles while an ack arrives. Required: IF/ID holds PC_out=0x008; captured word 0x00C appears the cycle after stall drops; next request address is 0x010.
4. branch_taken with target 0x123 while a request to 0x014 is outstanding, ack 1 cycle later. Required: IF/ID becomes NOP_INSTR with if_valid=0; the late 0x014 data is discarded; next imem_addr is 0x120; then PC_out=0x120, if_valid=1.
5. branch_taken and stall both high. Required: flush wins; NOP_INSTR in IF/ID; the held buffer is dropped.
6. PC=0x3FC with fetch streaming. Required: next imem_addr is 0x000. Separately, assert reset mid-request: imem_req=0 next cycle; all outputs return to reset values.
